// File: rtl/cordic_neuron_seq.sv
// cordic_neuron_seq
//   Evaluates one neuron y = act(bias + sum(x_i * w_i)) by time-multiplexing
//   a reconfigurable CORDIC core. Each input beat is one linear-mode core run
//   (z = Yo + Xo*Zo, with Yo = running sum). The core result is folded back into
//   the accumulator. After the last beat, one activation-mode run produces the
//   output. All data is signed Q6.10.
//
// Ports
//   clk, ext_reset_n        clock (rising edge), async active-low reset
//   in_valid/in_ready       input beat handshake; in_x, in_w, in_bias, in_last
//   out_valid/out_ready     result handshake; out_data
//   ovf                     one-cycle pulse when beat N_MAX arrives without in_last
//   c_Xo, c_Yo, c_Zo, c_sel core operands and mode select
//   c_reset                 core reset (active high), low only while a run is in flight
//   c_z                     core result
//   dbg_state               current FSM state, for observation
//
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high. Valid does not depend on ready, and once out_valid is raised it and
// out_data stay stable until accepted.
module cordic_neuron_seq #(
    parameter int             WIDTH      = 15,
    parameter int             N_MAX      = 16,
    parameter int             CORDIC_LAT = 32,
    parameter logic [1:0]     MUL_SEL    = 2'b00,
    parameter logic [1:0]     ACT_SEL    = 2'b01,
    parameter logic [WIDTH:0] ACT_X0     = 16'h0400
) (
    input  logic             clk,
    input  logic             ext_reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_x,
    input  logic [WIDTH:0]   in_w,
    input  logic [WIDTH:0]   in_bias,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_data,
    output logic             ovf,
    output logic [WIDTH:0]   c_Xo,
    output logic [WIDTH:0]   c_Yo,
    output logic [WIDTH:0]   c_Zo,
    output logic [1:0]       c_sel,
    output logic             c_reset,
    input  logic [WIDTH:0]   c_z,
    output logic [2:0]       dbg_state
);

    localparam int CNT_W  = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;
    localparam int BEAT_W = $clog2(N_MAX + 1);
    localparam logic [CNT_W-1:0]  RUN_LAST = CNT_W'(CORDIC_LAT - 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(N_MAX);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MAC_START = 3'd1,
        S_MAC_RUN   = 3'd2,
        S_WAIT_IN   = 3'd3,
        S_ACT_START = 3'd4,
        S_ACT_RUN   = 3'd5,
        S_OUT       = 3'd6
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH:0]    acc;
    logic [CNT_W-1:0]  run_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_nxt;
    logic              last_q;
    logic              hs_in;
    logic              run_last;

    assign hs_in     = in_valid && in_ready;
    assign run_last  = (run_cnt == RUN_LAST);
    assign beat_nxt  = (state == S_IDLE) ? BEAT_W'(1) : beat_cnt + BEAT_W'(1);
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or negedge ext_reset_n) begin
        if (!ext_reset_n) state <= S_IDLE;
        else              state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_WAIT_IN: if (hs_in) state_nxt = S_MAC_START;
            S_MAC_START:       state_nxt = S_MAC_RUN;
            S_MAC_RUN:         if (run_last) state_nxt = last_q ? S_ACT_START : S_WAIT_IN;
            S_ACT_START:       state_nxt = S_ACT_RUN;
            S_ACT_RUN:         if (run_last) state_nxt = S_OUT;
            S_OUT:             if (out_ready) state_nxt = S_IDLE;
            default:           state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready  = 1'b0;
        c_reset   = 1'b1;
        out_valid = 1'b0;
        case (state)
            S_IDLE, S_WAIT_IN:   in_ready  = 1'b1;
            S_MAC_RUN, S_ACT_RUN: c_reset  = 1'b0;
            S_OUT:               out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath. The core operand registers double as the latched x/w, so the
    // operands are loaded one edge before each *_START state and stay stable
    // through the following run.
    always_ff @(posedge clk or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            acc      <= '0;
            run_cnt  <= '0;
            beat_cnt <= '0;
            last_q   <= 1'b0;
            ovf      <= 1'b0;
            out_data <= '0;
            c_Xo     <= '0;
            c_Yo     <= '0;
            c_Zo     <= '0;
            c_sel    <= MUL_SEL;
        end else begin
            ovf <= 1'b0;

            if (state == S_MAC_RUN || state == S_ACT_RUN)
                run_cnt <= run_last ? '0 : run_cnt + CNT_W'(1);
            else
                run_cnt <= '0;

            if (hs_in) begin
                c_Xo     <= in_x;
                c_Zo     <= in_w;
                c_sel    <= MUL_SEL;
                beat_cnt <= beat_nxt;
                // Reaching N_MAX beats ends the neuron whether or not in_last is set.
                last_q   <= in_last || (beat_nxt == BEAT_MAX);
                ovf      <= !in_last && (beat_nxt == BEAT_MAX);
                if (state == S_IDLE) begin
                    acc  <= in_bias;
                    c_Yo <= in_bias;
                end else begin
                    c_Yo <= acc;
                end
            end

            if (state == S_MAC_RUN && run_last) begin
                acc <= c_z;
                if (last_q) begin
                    c_Xo  <= ACT_X0;
                    c_Yo  <= '0;
                    c_Zo  <= c_z;
                    c_sel <= ACT_SEL;
                end
            end

            if (state == S_ACT_RUN && run_last)
                out_data <= c_z;
        end
    end

endmodule

// File: tb/tb_cordic_neuron_seq.sv
module tb_cordic_neuron_seq;
  localparam int LAT   = 32;
  localparam int N_MAX = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic ext_reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [15:0] in_x = '0, in_w = '0, in_bias = '0;
  logic        in_ready, out_valid, ovf, c_reset;
  logic [15:0] out_data, c_Xo, c_Yo, c_Zo, c_z;
  logic [1:0]  c_sel;
  logic [2:0]  dbg_state;

  cordic_neuron_seq dut (
    .clk(clk), .ext_reset_n(ext_reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_bias(in_bias), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ovf(ovf), .c_Xo(c_Xo), .c_Yo(c_Yo), .c_Zo(c_Zo), .c_sel(c_sel),
    .c_reset(c_reset), .c_z(c_z), .dbg_state(dbg_state)
  );

  // ---------------- stub core ----------------
  // z is garbage until LAT-1 cycles after reset release, then
  // MAC: Yo + (Xo*Zo >>> 10), ACT: Zo.
  int run_k = 0;
  always @(posedge clk) begin
    if (c_reset) run_k <= 0;
    else         run_k <= run_k + 1;
  end
  logic signed [31:0] stub_p;
  always_comb begin
    stub_p = $signed(c_Xo) * $signed(c_Zo);
    if (c_reset || run_k < LAT - 1) c_z = 16'hBAD0;
    else if (c_sel == 2'b00)        c_z = c_Yo + stub_p[25:10];
    else                            c_z = c_Zo;
  end

  // ---------------- counters / check ----------------
  int compared = 0, mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event occurred with no expectation / timed out", name);
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] exp_yo_q[$], exp_act_q[$], exp_q[$];
  logic [15:0] m_acc = '0;
  int m_cnt = 0;
  bit m_first = 1'b1;
  int exp_ovf = 0, seen_ovf = 0;

  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 16'(p >>> 10);
  endfunction

  task automatic model_accept(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b,
                              input logic last, output bit last_eff, output bit ovf_e);
    if (m_first) begin m_acc = b; m_cnt = 1; end
    else m_cnt++;
    m_first  = 1'b0;
    exp_yo_q.push_back(m_acc);
    m_acc    = m_acc + qmul(x, w);
    last_eff = last || (m_cnt == N_MAX);
    ovf_e    = !last && (m_cnt == N_MAX);
    if (ovf_e) exp_ovf++;
    if (last_eff) begin
      exp_act_q.push_back(m_acc);
      exp_q.push_back(m_acc);
      m_first = 1'b1;
    end
  endtask

  task automatic model_reset();
    exp_yo_q.delete(); exp_act_q.delete(); exp_q.delete();
    m_first = 1'b1; m_cnt = 0;
  endtask

  // ---------------- compare process ----------------
  logic        prev_c_reset = 1'b1;
  logic [49:0] run_snap;
  logic [15:0] yo_log[$], act_log[$];
  logic [15:0] last_out = '0;

  always @(negedge clk) begin
    if (!ext_reset_n) begin
      prev_c_reset = 1'b1;
    end else begin
      if (!c_reset && prev_c_reset) begin
        run_snap = {c_Xo, c_Yo, c_Zo, c_sel};
        if (c_sel == 2'b00) begin
          yo_log.push_back(c_Yo);
          if (exp_yo_q.size() == 0) fail_now("mac_run_unexpected");
          else check("mac_c_Yo", c_Yo, exp_yo_q.pop_front());
        end else begin
          act_log.push_back(c_Zo);
          check("act_c_sel", c_sel, 2'b01);
          check("act_c_Xo", c_Xo, 16'h0400);
          check("act_c_Yo", c_Yo, 16'h0000);
          if (exp_act_q.size() == 0) fail_now("act_run_unexpected");
          else check("act_c_Zo", c_Zo, exp_act_q.pop_front());
        end
      end else if (!c_reset) begin
        check("operands_stable", {c_Xo, c_Yo, c_Zo, c_sel}, run_snap);
      end
      if (out_valid && out_ready) begin
        last_out = out_data;
        if (exp_q.size() == 0) fail_now("out_unexpected");
        else check("out_data", out_data, exp_q.pop_front());
      end
      if (ovf) seen_ovf++;
      prev_c_reset = c_reset;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_beat(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b,
                           input logic last, output bit last_eff);
    int t;
    bit ovf_e;
    t = 0;
    last_eff = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_x = x; in_w = w; in_bias = b; in_last = last;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      fail_now("in_ready_timeout");
      in_valid = 1'b0;
      return;
    end
    model_accept(x, w, b, last, last_eff, ovf_e);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("ovf_pulse", ovf, ovf_e);
  endtask

  // Called in cycle 1 after a handshake; returns the cycle index where in_ready
  // or out_valid is next seen high.
  task automatic wait_gap(output int k);
    k = 1;
    while (!in_ready && !out_valid && k < 300) begin @(negedge clk); k++; end
  endtask

  task automatic send_beat(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b,
                           input logic last);
    bit le;
    int k;
    push_beat(x, w, b, last, le);
    wait_gap(k);
    check(le ? "out_valid_latency" : "in_ready_gap", k, le ? 2 * LAT + 3 : LAT + 2);
    check("gap_end_kind", out_valid, le);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_ovf"}, ovf, 1'b0);
    check({tag, "_c_reset"}, c_reset, 1'b1);
    check({tag, "_c_ops"}, {c_Xo, c_Yo, c_Zo}, 48'h0);
    check({tag, "_c_sel"}, c_sel, 2'b00);
    check({tag, "_out_data"}, out_data, 16'h0000);
    check({tag, "_state"}, dbg_state, 3'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed test sequence ----------------
  initial begin
    bit le;
    int k;
    logic [15:0] held;

    #23;
    check_reset_vals("reset");
    @(posedge clk); #3 ext_reset_n = 1'b1;

    // Single beat: 0.5 * 0.25 = 0.125
    yo_log.delete(); act_log.delete();
    send_beat(16'h0200, 16'h0100, 16'h0000, 1'b1);
    @(negedge clk);
    check("single_yo_n", yo_log.size(), 1);
    if (yo_log.size() >= 1) check("single_yo_lit", yo_log[0], 16'h0000);
    check("single_act_n", act_log.size(), 1);
    if (act_log.size() >= 1) check("single_act_zo_lit", act_log[0], 16'h0080);
    check("single_out_lit", last_out, 16'h0080);

    // Three beats, bias 1.0
    yo_log.delete();
    send_beat(16'h0400, 16'h0200, 16'h0400, 1'b0);
    send_beat(16'hFE00, 16'h0400, 16'h7777, 1'b0);
    send_beat(16'h0100, 16'h0800, 16'h5555, 1'b1);
    @(negedge clk);
    check("three_yo_n", yo_log.size(), 3);
    if (yo_log.size() >= 3) begin
      check("three_yo0_lit", yo_log[0], 16'h0400);
      check("three_yo1_lit", yo_log[1], 16'h0600);
      check("three_yo2_lit", yo_log[2], 16'h0400);
    end
    check("three_out_lit", last_out, 16'h0600);

    // Backpressure: 0.75 * 1.0
    out_ready = 1'b0;
    push_beat(16'h0300, 16'h0400, 16'h0000, 1'b1, le);
    wait_gap(k);
    check("bp_latency", k, 2 * LAT + 3);
    held = out_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_stable", out_data, held);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1'b1);
    check("bp_release_out_valid", out_valid, 1'b0);
    check("bp_out_lit", last_out, 16'h0300);

    // Overflow: 16 beats of 1.0 * 0.0625 with no in_last, then a fresh neuron
    for (int i = 0; i < N_MAX; i++)
      send_beat(16'h0400, 16'h0040, (i == 0) ? 16'h0000 : 16'h1234, 1'b0);
    @(negedge clk);
    check("ovf_out_lit", last_out, 16'h0400);
    send_beat(16'h0400, 16'h0400, 16'h0100, 1'b1);
    @(negedge clk);
    check("post_ovf_out_lit", last_out, 16'h0500);

    // Mid-run reset during beat 2's MAC run
    send_beat(16'h0400, 16'h0400, 16'h0200, 1'b0);
    push_beat(16'h0400, 16'h0400, 16'h0000, 1'b0, le);
    repeat (10) @(negedge clk);
    @(posedge clk); #3 ext_reset_n = 1'b0;
    #1 check_reset_vals("midrun");
    model_reset();
    @(posedge clk); #3 ext_reset_n = 1'b1;

    // Fresh neuron after reset: 0.25 + 0.5 * -0.625 = -0.0625
    send_beat(16'h0200, 16'hFD80, 16'h0100, 1'b1);
    @(negedge clk);
    check("post_reset_out_lit", last_out, 16'hFFC0);

    repeat (3) @(negedge clk);
    check("ovf_count", seen_ovf, exp_ovf);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_yo_q_drained", exp_yo_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
